// File: rtl/rv64g_operand_fetch.sv
// rv64g_operand_fetch
//
// Issue-side partner of rv64g_regfile. Accepts one decoded instruction per
// cycle, checks its sources and destination against the regfile lock vector,
// reads up to three operands (forwarding a same-cycle writeback), locks the
// destination and hands a registered operand bundle to execute.
//
// Ports
//   clk_i, arst_ni                 clock (rising edge), async active-low reset
//   id_valid_i / id_ready_o        decoded-instruction handshake
//   id_payload_i                   opaque payload, passed through unchanged
//   id_use_i                       {use_rd, use_rs3, use_rs2, use_rs1}
//   id_rd/rs1/rs2/rs3_addr_i       register addresses of the instruction
//   locks_i                        regfile lock vector
//   rf_rs1/2/3_addr_o, _data_i     regfile combinational read ports
//   wb_unlock_en/addr/data_i       snoop of the writeback unlock port
//   wr_lock_en_o, wr_lock_addr_o   destination lock request (accept cycle only)
//   ex_valid_o / ex_ready_i        operand-bundle handshake
//   ex_payload_o, ex_rd_addr_o     registered payload and destination
//   ex_rs1/2/3_data_o              registered operands
//   stall_cnt_o                    saturating count of hazard-stall cycles

module rv64g_operand_fetch #(
    parameter int XLEN      = 64,
    parameter int NUM_REGS  = 32,
    parameter int PAYLOAD_W = 32,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                 clk_i,
    input  logic                 arst_ni,

    input  logic                 id_valid_i,
    output logic                 id_ready_o,
    input  logic [PAYLOAD_W-1:0] id_payload_i,
    input  logic [3:0]           id_use_i,
    input  logic [AW-1:0]        id_rd_addr_i,
    input  logic [AW-1:0]        id_rs1_addr_i,
    input  logic [AW-1:0]        id_rs2_addr_i,
    input  logic [AW-1:0]        id_rs3_addr_i,

    input  logic [NUM_REGS-1:0]  locks_i,

    output logic [AW-1:0]        rf_rs1_addr_o,
    output logic [AW-1:0]        rf_rs2_addr_o,
    output logic [AW-1:0]        rf_rs3_addr_o,
    input  logic [XLEN-1:0]      rf_rs1_data_i,
    input  logic [XLEN-1:0]      rf_rs2_data_i,
    input  logic [XLEN-1:0]      rf_rs3_data_i,

    input  logic                 wb_unlock_en_i,
    input  logic [AW-1:0]        wb_unlock_addr_i,
    input  logic [XLEN-1:0]      wb_unlock_data_i,

    output logic                 wr_lock_en_o,
    output logic [AW-1:0]        wr_lock_addr_o,

    output logic                 ex_valid_o,
    input  logic                 ex_ready_i,
    output logic [PAYLOAD_W-1:0] ex_payload_o,
    output logic [AW-1:0]        ex_rd_addr_o,
    output logic [XLEN-1:0]      ex_rs1_data_o,
    output logic [XLEN-1:0]      ex_rs2_data_o,
    output logic [XLEN-1:0]      ex_rs3_data_o,

    output logic [31:0]          stall_cnt_o
);

    // state | meaning
    // EMPTY | no operand bundle held; ex_valid_o low
    // FULL  | operand bundle held and presented to execute

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [NUM_REGS-1:0]  eff_lock;
    logic                 hazard;
    logic                 space;
    logic                 accept;
    logic                 stall_inc;

    logic [XLEN-1:0]      op1_d, op2_d, op3_d;

    logic [PAYLOAD_W-1:0] payload_q;
    logic [AW-1:0]        rd_q;
    logic [XLEN-1:0]      op1_q, op2_q, op3_q;
    logic [31:0]          stall_q;

    assign rf_rs1_addr_o = id_rs1_addr_i;
    assign rf_rs2_addr_o = id_rs2_addr_i;
    assign rf_rs3_addr_o = id_rs3_addr_i;

    // A register being unlocked this cycle is already free: its value is
    // forwarded from the writeback bus. x0 is never treated as locked.
    always_comb begin
        eff_lock = locks_i;
        if (wb_unlock_en_i) begin
            eff_lock[wb_unlock_addr_i] = 1'b0;
        end
        eff_lock[0] = 1'b0;
    end

    assign hazard = (id_use_i[0] & eff_lock[id_rs1_addr_i])
                  | (id_use_i[1] & eff_lock[id_rs2_addr_i])
                  | (id_use_i[2] & eff_lock[id_rs3_addr_i])
                  | (id_use_i[3] & eff_lock[id_rd_addr_i]);

    function automatic logic [XLEN-1:0] pick_operand(
        input logic            used,
        input logic [AW-1:0]   addr,
        input logic [XLEN-1:0] rf_data,
        input logic            wb_en,
        input logic [AW-1:0]   wb_addr,
        input logic [XLEN-1:0] wb_data
    );
        if (!used || addr == '0) begin
            return '0;
        end
        if (wb_en && wb_addr == addr) begin
            return wb_data;
        end
        return rf_data;
    endfunction

    always_comb begin
        op1_d = pick_operand(id_use_i[0], id_rs1_addr_i, rf_rs1_data_i,
                             wb_unlock_en_i, wb_unlock_addr_i, wb_unlock_data_i);
        op2_d = pick_operand(id_use_i[1], id_rs2_addr_i, rf_rs2_data_i,
                             wb_unlock_en_i, wb_unlock_addr_i, wb_unlock_data_i);
        op3_d = pick_operand(id_use_i[2], id_rs3_addr_i, rf_rs3_data_i,
                             wb_unlock_en_i, wb_unlock_addr_i, wb_unlock_data_i);
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A held bundle being consumed this cycle frees the slot, so a new
    // instruction can be accepted in the same cycle (full throughput).
    always_comb begin
        state_d      = state_q;
        space        = 1'b0;
        id_ready_o   = 1'b0;
        accept       = 1'b0;
        wr_lock_en_o = 1'b0;
        stall_inc    = 1'b0;

        space        = (state_q == EMPTY) | ((state_q == FULL) & ex_ready_i);
        id_ready_o   = arst_ni & space & ~(id_valid_i & hazard);
        accept       = id_valid_i & id_ready_o;
        wr_lock_en_o = accept & id_use_i[3] & (id_rd_addr_i != '0);
        stall_inc    = id_valid_i & space & hazard;

        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (accept) begin
                    state_d = FULL;
                end else if (ex_ready_i) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // The lock request carries the destination unconditionally; it only
    // takes effect when wr_lock_en_o is high, and the regfile gives it
    // priority over a same-cycle unlock of the same register.
    assign wr_lock_addr_o = id_rd_addr_i;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            payload_q <= '0;
            rd_q      <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            op3_q     <= '0;
        end else if (accept) begin
            payload_q <= id_payload_i;
            rd_q      <= id_rd_addr_i;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            op3_q     <= op3_d;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            stall_q <= '0;
        end else if (stall_inc && stall_q != 32'hFFFF_FFFF) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign ex_valid_o    = (state_q == FULL);
    assign ex_payload_o  = payload_q;
    assign ex_rd_addr_o  = rd_q;
    assign ex_rs1_data_o = op1_q;
    assign ex_rs2_data_o = op2_q;
    assign ex_rs3_data_o = op3_q;
    assign stall_cnt_o   = stall_q;

endmodule

// File: tb/tb_rv64g_operand_fetch.sv
module tb_rv64g_operand_fetch;

    localparam int XLEN      = 64;
    localparam int NUM_REGS  = 32;
    localparam int PAYLOAD_W = 32;
    localparam int AW        = 5;

    logic                 clk_i;
    logic                 arst_ni;
    logic                 id_valid_i;
    logic                 id_ready_o;
    logic [PAYLOAD_W-1:0] id_payload_i;
    logic [3:0]           id_use_i;
    logic [AW-1:0]        id_rd_addr_i;
    logic [AW-1:0]        id_rs1_addr_i;
    logic [AW-1:0]        id_rs2_addr_i;
    logic [AW-1:0]        id_rs3_addr_i;
    logic [NUM_REGS-1:0]  locks_i;
    logic [AW-1:0]        rf_rs1_addr_o;
    logic [AW-1:0]        rf_rs2_addr_o;
    logic [AW-1:0]        rf_rs3_addr_o;
    logic [XLEN-1:0]      rf_rs1_data_i;
    logic [XLEN-1:0]      rf_rs2_data_i;
    logic [XLEN-1:0]      rf_rs3_data_i;
    logic                 wb_unlock_en_i;
    logic [AW-1:0]        wb_unlock_addr_i;
    logic [XLEN-1:0]      wb_unlock_data_i;
    logic                 wr_lock_en_o;
    logic [AW-1:0]        wr_lock_addr_o;
    logic                 ex_valid_o;
    logic                 ex_ready_i;
    logic [PAYLOAD_W-1:0] ex_payload_o;
    logic [AW-1:0]        ex_rd_addr_o;
    logic [XLEN-1:0]      ex_rs1_data_o;
    logic [XLEN-1:0]      ex_rs2_data_o;
    logic [XLEN-1:0]      ex_rs3_data_o;
    logic [31:0]          stall_cnt_o;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_stall = 32'd0;

    rv64g_operand_fetch #(
        .XLEN(XLEN), .NUM_REGS(NUM_REGS), .PAYLOAD_W(PAYLOAD_W)
    ) dut (
        .clk_i(clk_i), .arst_ni(arst_ni),
        .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
        .id_payload_i(id_payload_i), .id_use_i(id_use_i),
        .id_rd_addr_i(id_rd_addr_i), .id_rs1_addr_i(id_rs1_addr_i),
        .id_rs2_addr_i(id_rs2_addr_i), .id_rs3_addr_i(id_rs3_addr_i),
        .locks_i(locks_i),
        .rf_rs1_addr_o(rf_rs1_addr_o), .rf_rs2_addr_o(rf_rs2_addr_o),
        .rf_rs3_addr_o(rf_rs3_addr_o),
        .rf_rs1_data_i(rf_rs1_data_i), .rf_rs2_data_i(rf_rs2_data_i),
        .rf_rs3_data_i(rf_rs3_data_i),
        .wb_unlock_en_i(wb_unlock_en_i), .wb_unlock_addr_i(wb_unlock_addr_i),
        .wb_unlock_data_i(wb_unlock_data_i),
        .wr_lock_en_o(wr_lock_en_o), .wr_lock_addr_o(wr_lock_addr_o),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .ex_payload_o(ex_payload_o), .ex_rd_addr_o(ex_rd_addr_o),
        .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
        .ex_rs3_data_o(ex_rs3_data_o),
        .stall_cnt_o(stall_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (ex_valid_o !== 1'b0) begin failures++; $display("FAIL reset_ex_valid got=%0b exp=0", ex_valid_o); end
        checks++; if (id_ready_o !== 1'b0) begin failures++; $display("FAIL reset_id_ready got=%0b exp=0", id_ready_o); end
        checks++; if (stall_cnt_o !== 32'd0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt_o); end
        checks++; if (wr_lock_en_o !== 1'b0) begin failures++; $display("FAIL reset_wr_lock got=%0b exp=0", wr_lock_en_o); end
        repeat (2) @(posedge clk_i);
        #2 arst_ni = 1'b1;
        tick();
        checks++; if (id_ready_o !== 1'b1) begin failures++; $display("FAIL idle_id_ready got=%0b exp=1", id_ready_o); end
    endtask

    task automatic test_basic();
        ex_ready_i = 1'b1; id_valid_i = 1'b1; id_payload_i = 32'hCAFE_0001;
        id_use_i = 4'b1011; id_rd_addr_i = 5'd5; id_rs1_addr_i = 5'd3;
        id_rs2_addr_i = 5'd4; id_rs3_addr_i = 5'd6;
        rf_rs1_data_i = 64'h11; rf_rs2_data_i = 64'h22; rf_rs3_data_i = 64'h33;
        #1;
        checks++; if (id_ready_o !== 1'b1) begin failures++; $display("FAIL basic_ready got=%0b exp=1", id_ready_o); end
        checks++; if (wr_lock_en_o !== 1'b1) begin failures++; $display("FAIL basic_lock_en got=%0b exp=1", wr_lock_en_o); end
        checks++; if (wr_lock_addr_o !== 5'd5) begin failures++; $display("FAIL basic_lock_addr got=%0d exp=5", wr_lock_addr_o); end
        checks++; if (rf_rs2_addr_o !== 5'd4) begin failures++; $display("FAIL basic_rf_addr2 got=%0d exp=4", rf_rs2_addr_o); end
        tick();
        id_valid_i = 1'b0;
        #1;
        checks++; if (ex_valid_o !== 1'b1) begin failures++; $display("FAIL basic_ex_valid got=%0b exp=1", ex_valid_o); end
        checks++; if (ex_rs1_data_o !== 64'h11) begin failures++; $display("FAIL basic_rs1 got=%0h exp=11", ex_rs1_data_o); end
        checks++; if (ex_rs2_data_o !== 64'h22) begin failures++; $display("FAIL basic_rs2 got=%0h exp=22", ex_rs2_data_o); end
        checks++; if (ex_rs3_data_o !== 64'h0) begin failures++; $display("FAIL basic_rs3_unused got=%0h exp=0", ex_rs3_data_o); end
        checks++; if (ex_rd_addr_o !== 5'd5) begin failures++; $display("FAIL basic_rd got=%0d exp=5", ex_rd_addr_o); end
        checks++; if (ex_payload_o !== 32'hCAFE_0001) begin failures++; $display("FAIL basic_payload got=%0h exp=cafe0001", ex_payload_o); end
        checks++; if (wr_lock_en_o !== 1'b0) begin failures++; $display("FAIL basic_lock_idle got=%0b exp=0", wr_lock_en_o); end
        tick();
        checks++; if (ex_valid_o !== 1'b0) begin failures++; $display("FAIL basic_consumed got=%0b exp=0", ex_valid_o); end
    endtask

    task automatic test_stall();
        locks_i = 32'h0000_0008; id_valid_i = 1'b1; id_payload_i = 32'hCAFE_0002;
        id_use_i = 4'b0001; id_rs1_addr_i = 5'd3; id_rd_addr_i = 5'd0;
        rf_rs1_data_i = 64'h99;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (id_ready_o !== 1'b0) begin failures++; $display("FAIL stall_ready cyc=%0d got=%0b exp=0", i, id_ready_o); end
            tick();
        end
        exp_stall = exp_stall + 32'd4;
        checks++; if (stall_cnt_o !== exp_stall) begin failures++; $display("FAIL stall_count got=%0d exp=%0d", stall_cnt_o, exp_stall); end
        wb_unlock_en_i = 1'b1; wb_unlock_addr_i = 5'd3; wb_unlock_data_i = 64'hDEAD;
        #1;
        checks++; if (id_ready_o !== 1'b1) begin failures++; $display("FAIL stall_unlock_ready got=%0b exp=1", id_ready_o); end
        tick();
        id_valid_i = 1'b0; wb_unlock_en_i = 1'b0; locks_i = '0;
        #1;
        checks++; if (ex_rs1_data_o !== 64'hDEAD) begin failures++; $display("FAIL stall_forward got=%0h exp=dead", ex_rs1_data_o); end
        checks++; if (stall_cnt_o !== exp_stall) begin failures++; $display("FAIL stall_hold got=%0d exp=%0d", stall_cnt_o, exp_stall); end
        tick();
    endtask

    task automatic test_waw();
        locks_i = 32'h0000_0200; id_valid_i = 1'b1; id_payload_i = 32'hCAFE_0003;
        id_use_i = 4'b1000; id_rd_addr_i = 5'd9;
        #1;
        checks++; if (id_ready_o !== 1'b0) begin failures++; $display("FAIL waw_ready got=%0b exp=0", id_ready_o); end
        checks++; if (wr_lock_en_o !== 1'b0) begin failures++; $display("FAIL waw_no_lock got=%0b exp=0", wr_lock_en_o); end
        tick();
        exp_stall = exp_stall + 32'd1;
        checks++; if (stall_cnt_o !== exp_stall) begin failures++; $display("FAIL waw_stall got=%0d exp=%0d", stall_cnt_o, exp_stall); end
        wb_unlock_en_i = 1'b1; wb_unlock_addr_i = 5'd9; wb_unlock_data_i = 64'h1234;
        #1;
        checks++; if (id_ready_o !== 1'b1) begin failures++; $display("FAIL waw_unlock_ready got=%0b exp=1", id_ready_o); end
        checks++; if (wr_lock_en_o !== 1'b1 || wr_lock_addr_o !== 5'd9) begin failures++; $display("FAIL waw_relock got=%0b/%0d exp=1/9", wr_lock_en_o, wr_lock_addr_o); end
        tick();
        id_valid_i = 1'b0; wb_unlock_en_i = 1'b0; locks_i = '0;
        #1;
        checks++; if (ex_valid_o !== 1'b1 || ex_rd_addr_o !== 5'd9) begin failures++; $display("FAIL waw_bundle got=%0b/%0d exp=1/9", ex_valid_o, ex_rd_addr_o); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] pl [3];
        logic [63:0] dat [3];
        pl[0] = 32'hB0B0_000B; pl[1] = 32'hC0C0_000C; pl[2] = 32'hD0D0_000D;
        dat[0] = 64'hB1; dat[1] = 64'hC1; dat[2] = 64'hD1;
        ex_ready_i = 1'b0; id_valid_i = 1'b1; id_payload_i = 32'hA0A0_000A;
        id_use_i = 4'b1001; id_rd_addr_i = 5'd1; id_rs1_addr_i = 5'd2;
        rf_rs1_data_i = 64'hA1;
        #1;
        checks++; if (id_ready_o !== 1'b1) begin failures++; $display("FAIL b2b_first_ready got=%0b exp=1", id_ready_o); end
        tick();
        id_payload_i = pl[0]; id_rd_addr_i = 5'd2; rf_rs1_data_i = dat[0];
        #1;
        checks++; if (id_ready_o !== 1'b0) begin failures++; $display("FAIL b2b_full_ready got=%0b exp=0", id_ready_o); end
        tick();
        tick();
        checks++; if (ex_valid_o !== 1'b1 || ex_payload_o !== 32'hA0A0_000A || ex_rs1_data_o !== 64'hA1) begin
            failures++; $display("FAIL b2b_hold got=%0b/%0h/%0h exp=1/a0a0000a/a1", ex_valid_o, ex_payload_o, ex_rs1_data_o); end
        checks++; if (stall_cnt_o !== exp_stall) begin failures++; $display("FAIL b2b_no_stall got=%0d exp=%0d", stall_cnt_o, exp_stall); end
        ex_ready_i = 1'b1;
        #1;
        checks++; if (id_ready_o !== 1'b1) begin failures++; $display("FAIL b2b_release_ready got=%0b exp=1", id_ready_o); end
        for (int i = 0; i < 3; i++) begin
            id_payload_i = pl[i]; rf_rs1_data_i = dat[i];
            tick();
            checks++; if (ex_valid_o !== 1'b1 || ex_payload_o !== pl[i] || ex_rs1_data_o !== dat[i]) begin
                failures++; $display("FAIL b2b_bundle%0d got=%0b/%0h/%0h exp=1/%0h/%0h", i, ex_valid_o, ex_payload_o, ex_rs1_data_o, pl[i], dat[i]); end
        end
        id_valid_i = 1'b0;
        tick();
        checks++; if (ex_valid_o !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0b exp=0", ex_valid_o); end
    endtask

    task automatic test_zero();
        locks_i = '1; ex_ready_i = 1'b1; id_valid_i = 1'b1; id_payload_i = 32'h0000_0F0F;
        id_use_i = 4'b1001; id_rs1_addr_i = 5'd0; id_rd_addr_i = 5'd0;
        rf_rs1_data_i = 64'h55;
        #1;
        checks++; if (id_ready_o !== 1'b1) begin failures++; $display("FAIL zero_ready got=%0b exp=1", id_ready_o); end
        checks++; if (wr_lock_en_o !== 1'b0) begin failures++; $display("FAIL zero_lock got=%0b exp=0", wr_lock_en_o); end
        tick();
        id_valid_i = 1'b0;
        #1;
        checks++; if (ex_valid_o !== 1'b1 || ex_rs1_data_o !== 64'h0) begin failures++; $display("FAIL zero_operand got=%0b/%0h exp=1/0", ex_valid_o, ex_rs1_data_o); end
        checks++; if (stall_cnt_o !== exp_stall) begin failures++; $display("FAIL zero_no_stall got=%0d exp=%0d", stall_cnt_o, exp_stall); end
        tick();
        locks_i = '0;
    endtask

    task automatic test_reset_mid();
        locks_i = 32'h0000_0008; ex_ready_i = 1'b1; id_valid_i = 1'b1;
        id_use_i = 4'b0001; id_rs1_addr_i = 5'd3; id_rd_addr_i = 5'd0;
        tick();
        tick();
        exp_stall = exp_stall + 32'd2;
        checks++; if (stall_cnt_o !== exp_stall) begin failures++; $display("FAIL mid_stall got=%0d exp=%0d", stall_cnt_o, exp_stall); end
        locks_i = '0; id_payload_i = 32'h7777_0007; rf_rs1_data_i = 64'h77;
        tick();
        ex_ready_i = 1'b0; locks_i = 32'h0000_0008;
        #1;
        checks++; if (ex_valid_o !== 1'b1 || id_ready_o !== 1'b0) begin failures++; $display("FAIL mid_full got=%0b/%0b exp=1/0", ex_valid_o, id_ready_o); end
        #1 arst_ni = 1'b0;
        #1;
        checks++; if (ex_valid_o !== 1'b0) begin failures++; $display("FAIL mid_ex_valid got=%0b exp=0", ex_valid_o); end
        checks++; if (stall_cnt_o !== 32'd0) begin failures++; $display("FAIL mid_stall_clr got=%0d exp=0", stall_cnt_o); end
        checks++; if (id_ready_o !== 1'b0) begin failures++; $display("FAIL mid_ready got=%0b exp=0", id_ready_o); end
        checks++; if (ex_payload_o !== 32'd0 || ex_rs1_data_o !== 64'd0) begin failures++; $display("FAIL mid_data_clr got=%0h/%0h exp=0/0", ex_payload_o, ex_rs1_data_o); end
        exp_stall = 32'd0;
        id_valid_i = 1'b0; locks_i = '0;
        tick();
        #2 arst_ni = 1'b1;
        tick();
        checks++; if (ex_valid_o !== 1'b0 || id_ready_o !== 1'b1) begin failures++; $display("FAIL mid_recover got=%0b/%0b exp=0/1", ex_valid_o, id_ready_o); end
    endtask

    initial begin
        arst_ni = 1'b0; id_valid_i = 1'b0; id_payload_i = '0; id_use_i = '0;
        id_rd_addr_i = '0; id_rs1_addr_i = '0; id_rs2_addr_i = '0; id_rs3_addr_i = '0;
        locks_i = '0; rf_rs1_data_i = '0; rf_rs2_data_i = '0; rf_rs3_data_i = '0;
        wb_unlock_en_i = 1'b0; wb_unlock_addr_i = '0; wb_unlock_data_i = '0;
        ex_ready_i = 1'b1;

        test_reset();
        test_basic();
        test_stall();
        test_waw();
        test_back_to_back();
        test_zero();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
